// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link. Rebuilds channels a..d from a serial beat stream
// whose frame starts are marked by frame_sync. All four outputs update on one edge.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       s,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       s_q;
  logic [1:0]       s_d;
  logic [WIDTH-1:0] stage0_q, stage1_q, stage2_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             frame_done_q;
  logic             sync_err_q;

  assign s_d = s_q + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      s_q          <= 2'd0;
      stage0_q     <= '0;
      stage1_q     <= '0;
      stage2_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (valid) begin
        case (state_q)
          HUNT: begin
            if (frame_sync) begin
              stage0_q <= i;
              s_q      <= 2'd1;
              state_q  <= RUN;
            end
          end
          RUN: begin
            if (frame_sync) begin
              // A sync beat always restarts the frame; it is an error only mid-frame.
              stage0_q <= i;
              s_q      <= 2'd1;
              if (s_q != 2'd0) sync_err_q <= 1'b1;
            end else if (s_q == 2'd0) begin
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
            end else if (s_q == 2'd3) begin
              a_q          <= stage0_q;
              b_q          <= stage1_q;
              c_q          <= stage2_q;
              d_q          <= i;
              frame_done_q <= 1'b1;
              s_q          <= 2'd0;
            end else begin
              if (s_q == 2'd1) stage1_q <= i;
              else             stage2_q <= i;
              s_q <= s_d;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign d          = d_q;
  assign s          = s_q;
  assign locked     = (state_q == RUN);
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a queue-based frame model checked every cycle,
// plus literal expectations after each scenario.
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] i = '0;
  logic         valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   s;
  logic         locked, frame_done, sync_err;

  int checks = 0;
  int failures = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .valid(valid), .frame_sync(frame_sync),
    .a(a), .b(b), .c(c), .d(d), .s(s), .locked(locked),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Model: the beats of the frame in progress are held in a queue; its length is the slot.
  logic [W-1:0] mq[$];
  bit           m_lock = 0;
  logic [W-1:0] ma = '0, mb = '0, mc = '0, md = '0;
  bit           m_done = 0, m_err = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_lock = 0; m_done = 0; m_err = 0;
      ma = '0; mb = '0; mc = '0; md = '0;
    end else begin
      m_done = 0; m_err = 0;
      if (valid) begin
        if (!m_lock) begin
          if (frame_sync) begin
            mq = {i};
            m_lock = 1;
          end
        end else if (frame_sync) begin
          if (mq.size() != 0) m_err = 1;
          mq = {i};
        end else if (mq.size() == 0) begin
          m_err = 1;
          m_lock = 0;
        end else begin
          mq.push_back(i);
          if (mq.size() == 4) begin
            ma = mq[0]; mb = mq[1]; mc = mq[2]; md = mq[3];
            m_done = 1;
            mq.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("a", 32'(a), 32'(ma));
    chk("b", 32'(b), 32'(mb));
    chk("c", 32'(c), 32'(mc));
    chk("d", 32'(d), 32'(md));
    chk("s", 32'(s), 32'(mq.size()));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("done_err_exclusive", 32'(frame_done & sync_err), 32'd0);
    if (m_done) $display("frame t=%0t a=%0h b=%0h c=%0h d=%0h", $time, a, b, c, d);
    if (m_err)  $display("sync_err t=%0t", $time);
  end

  task automatic beat(input logic fs, input logic [W-1:0] v);
    @(negedge clk);
    valid = 1'b1; frame_sync = fs; i = v;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid = 1'b0; frame_sync = 1'b0; i = '0;
    end
  endtask

  task automatic expect_abcd(input string nm, input logic [W-1:0] ea, input logic [W-1:0] eb,
                             input logic [W-1:0] ec, input logic [W-1:0] ed);
    chk({nm, "_a"}, 32'(a), 32'(ea));
    chk({nm, "_b"}, 32'(b), 32'(eb));
    chk({nm, "_c"}, 32'(c), 32'(ec));
    chk({nm, "_d"}, 32'(d), 32'(ed));
  endtask

  initial begin
    #3;
    expect_abcd("reset", 0, 0, 0, 0);
    chk("reset_s", 32'(s), 0);
    chk("reset_locked", 32'(locked), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Basic frame 1,0,1,0 at full rate.
    beat(1, 1);
    beat(0, 0);
    chk("t1_s1", 32'(s), 1);
    chk("t1_locked", 32'(locked), 1);
    beat(0, 1);
    chk("t1_s2", 32'(s), 2);
    beat(0, 0);
    chk("t1_s3", 32'(s), 3);
    idle(1);
    expect_abcd("t1", 1, 0, 1, 0);
    chk("t1_done", 32'(frame_done), 1);
    chk("t1_s_wrap", 32'(s), 0);
    idle(1);
    chk("t1_done_pulse", 32'(frame_done), 0);

    // Same frame with idle gaps.
    beat(1, 1); idle(2);
    chk("t2_s_hold", 32'(s), 1);
    beat(0, 0); idle(2);
    beat(0, 1); idle(2);
    chk("t2_no_done", 32'(frame_done), 0);
    beat(0, 0); idle(1);
    expect_abcd("t2", 1, 0, 1, 0);
    chk("t2_done", 32'(frame_done), 1);

    // Back-to-back frames.
    beat(1, 1); beat(0, 1); beat(0, 0); beat(0, 1);
    beat(1, 0);
    expect_abcd("t3_f1", 1, 1, 0, 1);
    beat(0, 1); beat(0, 0); beat(0, 1);
    idle(1);
    expect_abcd("t3_f2", 0, 1, 0, 1);

    // Early sync after a reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    beat(1, 1); beat(0, 0); beat(1, 0);
    beat(0, 1);
    chk("t4_err", 32'(sync_err), 1);
    expect_abcd("t4_hold", 0, 0, 0, 0);
    beat(0, 1); beat(0, 1);
    idle(1);
    expect_abcd("t4", 0, 1, 1, 1);
    chk("t4_locked", 32'(locked), 1);

    // Missing sync, ignored beats, relock with multi-bit data.
    beat(0, 4'h5);
    idle(1);
    chk("t5_err", 32'(sync_err), 1);
    chk("t5_unlocked", 32'(locked), 0);
    beat(0, 4'h6); beat(0, 4'h7);
    beat(1, 4'h3); beat(0, 4'h7); beat(0, 4'h9); beat(0, 4'hF);
    idle(1);
    expect_abcd("t5", 4'h3, 4'h7, 4'h9, 4'hF);

    // Asynchronous reset mid-frame.
    beat(1, 1); beat(0, 1); beat(0, 1); beat(0, 1);
    beat(1, 4'h2); beat(0, 4'h2);
    idle(1);
    expect_abcd("t6_pre", 1, 1, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    expect_abcd("t6_async", 0, 0, 0, 0);
    chk("t6_s", 32'(s), 0);
    chk("t6_locked", 32'(locked), 0);
    idle(1);
    rst_n = 1'b1;
    beat(1, 4'hA); beat(0, 4'hB); beat(0, 4'hC); beat(0, 4'hD);
    idle(2);
    expect_abcd("t6_post", 4'hA, 4'hB, 4'hC, 4'hD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
